// File: rtl/xpu_vpu_pc_tn_vrf_vlsu_st_pack_if.sv
// xpu_vpu_pc_tn_vrf_vlsu_st_pack_if: issue-queue, VRF read-port and VLSU store-channel signals.
interface xpu_vpu_pc_tn_vrf_vlsu_st_pack_if #(
  parameter int LANE_VLEN = 128,
  parameter int VIS_WIDTH = 852,
  parameter int UID_WIDTH = 8
);
  logic                 iq_vrf_st_vld, vrf_iq_st_rdy, iq_vrf_st_op_last;
  logic [UID_WIDTH-1:0] iq_vrf_st_uid;
  logic [21:0]          iq_vrf_st_func;
  logic [1:0]           iq_vrf_st_vsew;
  logic [15:0]          iq_vrf_st_vmask;
  logic [4:0]           iq_vrf_st_vimm, iq_vrf_st_ele_len, iq_vrf_st_vstart_len;
  logic [63:0]          iq_vrf_st_src1;
  logic [3:0]           iq_vrf_st_src_mask;
  logic [4:0]           iq_vrf_st_vreg0, iq_vrf_st_vreg1, iq_vrf_st_vreg2, iq_vrf_st_vreg3;
  logic                 vrf_rd_req;
  logic [4:0]           vrf_rd_idx;
  logic [LANE_VLEN-1:0] vrf_rd_data;
  logic                 vrf_vlsu_st_vld, vlsu_vrf_st_rdy;
  logic [VIS_WIDTH-1:0] vrf_vlsu_st_info;
  logic [LANE_VLEN-1:0] vrf_vlsu_st_srcv0_data, vrf_vlsu_st_srcv1_data;
  logic [LANE_VLEN-1:0] vrf_vlsu_st_srcv2_data, vrf_vlsu_st_srcv3_data;
  modport slave (
    input  iq_vrf_st_vld, iq_vrf_st_uid, iq_vrf_st_func, iq_vrf_st_vsew, iq_vrf_st_vmask,
           iq_vrf_st_vimm, iq_vrf_st_ele_len, iq_vrf_st_vstart_len, iq_vrf_st_op_last,
           iq_vrf_st_src1, iq_vrf_st_src_mask, iq_vrf_st_vreg0, iq_vrf_st_vreg1,
           iq_vrf_st_vreg2, iq_vrf_st_vreg3, vrf_rd_data, vlsu_vrf_st_rdy,
    output vrf_iq_st_rdy, vrf_rd_req, vrf_rd_idx, vrf_vlsu_st_vld, vrf_vlsu_st_info,
           vrf_vlsu_st_srcv0_data, vrf_vlsu_st_srcv1_data, vrf_vlsu_st_srcv2_data,
           vrf_vlsu_st_srcv3_data
  );
  modport master (
    output iq_vrf_st_vld, iq_vrf_st_uid, iq_vrf_st_func, iq_vrf_st_vsew, iq_vrf_st_vmask,
           iq_vrf_st_vimm, iq_vrf_st_ele_len, iq_vrf_st_vstart_len, iq_vrf_st_op_last,
           iq_vrf_st_src1, iq_vrf_st_src_mask, iq_vrf_st_vreg0, iq_vrf_st_vreg1,
           iq_vrf_st_vreg2, iq_vrf_st_vreg3, vrf_rd_data, vlsu_vrf_st_rdy,
    input  vrf_iq_st_rdy, vrf_rd_req, vrf_rd_idx, vrf_vlsu_st_vld, vrf_vlsu_st_info,
           vrf_vlsu_st_srcv0_data, vrf_vlsu_st_srcv1_data, vrf_vlsu_st_srcv2_data,
           vrf_vlsu_st_srcv3_data
  );
endinterface

// File: rtl/xpu_vpu_pc_tn_vrf_vlsu_st_pack.sv
// xpu_vpu_pc_tn_vrf_vlsu_st_pack: reads a store uop's source vregs and packs it for the VLSU.
// Define XPU_VPU_PC_TN_VLSU_ST_FLUSH_EN to add the rtu_vpu_flush port and flush path.
`ifndef XPU_VPU_PC_TN_VIS_UID
`define XPU_VPU_PC_TN_VIS_UID        7
`define XPU_VPU_PC_TN_VIS_FUNC       29
`define XPU_VPU_PC_TN_VIS_VSEW       31
`define XPU_VPU_PC_TN_VIS_SRCVM      47
`define XPU_VPU_PC_TN_VIS_VIMM       52
`define XPU_VPU_PC_TN_VIS_ELE_LEN    57
`define XPU_VPU_PC_TN_VIS_VSTART_LEN 62
`define XPU_VPU_PC_TN_VIS_OP_LAST    63
`define XPU_VPU_PC_TN_VIS_SRC1       127
`endif
module xpu_vpu_pc_tn_vrf_vlsu_st_pack #(
  parameter int LANE_VLEN = 128,
  parameter int VIS_WIDTH = 852,
  parameter int UID_WIDTH = 8,
  parameter int NUM_SRC   = 4
) (
  input logic cpuclk,
  input logic cpurst_b,
`ifdef XPU_VPU_PC_TN_VLSU_ST_FLUSH_EN
  input logic rtu_vpu_flush,
`endif
  xpu_vpu_pc_tn_vrf_vlsu_st_pack_if.slave st
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, OUT} st_e;
  st_e                                  r_st;
  logic                                 r_act, r_vld, r_rd_req, r_rtn_vld;
  logic [NUM_SRC-1:0]                   r_pend;
  logic [1:0]                           r_rd_slot, r_rtn_slot;
  logic [4:0]                           r_rd_idx;
  logic [NUM_SRC-1:0][4:0]              r_vreg;
  logic [NUM_SRC-1:0][LANE_VLEN-1:0]    r_data;
  logic [VIS_WIDTH-1:0]                 r_info, w_info;
  logic                                 w_flush, w_acc, w_hs;
  logic [NUM_SRC-1:0]                   w_mask, w_nxt;
  logic [1:0]                           w_slot;
  logic [NUM_SRC-1:0][4:0]              w_vreg;
`ifdef XPU_VPU_PC_TN_VLSU_ST_FLUSH_EN
  assign w_flush = rtu_vpu_flush;
`else
  assign w_flush = 1'b0;
`endif
  // r_act keeps rdy low while in reset and for the first cycle after release
  assign st.vrf_iq_st_rdy = r_act & ~w_flush & ((r_st == IDLE) | ((r_st == OUT) & st.vlsu_vrf_st_rdy));
  assign w_acc  = st.iq_vrf_st_vld & st.vrf_iq_st_rdy;
  assign w_hs   = r_vld & st.vlsu_vrf_st_rdy;
  assign w_vreg = {st.iq_vrf_st_vreg3, st.iq_vrf_st_vreg2, st.iq_vrf_st_vreg1, st.iq_vrf_st_vreg0};
  assign w_mask = w_acc ? st.iq_vrf_st_src_mask : r_pend;
  assign w_slot = w_mask[0] ? 2'd0 : w_mask[1] ? 2'd1 : w_mask[2] ? 2'd2 : 2'd3;
  assign w_nxt  = w_mask & ~(4'b1 << w_slot);
  always_comb begin
    w_info = '0;
    w_info[`XPU_VPU_PC_TN_VIS_UID -: UID_WIDTH] = st.iq_vrf_st_uid;
    w_info[`XPU_VPU_PC_TN_VIS_FUNC -: 22]       = st.iq_vrf_st_func;
    w_info[`XPU_VPU_PC_TN_VIS_VSEW -: 2]        = st.iq_vrf_st_vsew;
    w_info[`XPU_VPU_PC_TN_VIS_SRCVM -: 16]      = st.iq_vrf_st_vmask;
    w_info[`XPU_VPU_PC_TN_VIS_VIMM -: 5]        = st.iq_vrf_st_vimm;
    w_info[`XPU_VPU_PC_TN_VIS_ELE_LEN -: 5]     = st.iq_vrf_st_ele_len;
    w_info[`XPU_VPU_PC_TN_VIS_VSTART_LEN -: 5]  = st.iq_vrf_st_vstart_len;
    w_info[`XPU_VPU_PC_TN_VIS_OP_LAST]          = st.iq_vrf_st_op_last;
    w_info[`XPU_VPU_PC_TN_VIS_SRC1 -: 64]       = st.iq_vrf_st_src1;
  end
  always_ff @(posedge cpuclk or negedge cpurst_b)
    if (!cpurst_b) begin
      r_st       <= IDLE;
      r_act      <= 1'b0;
      r_vld      <= 1'b0;
      r_rd_req   <= 1'b0;
      r_rtn_vld  <= 1'b0;
      r_pend     <= '0;
      r_rd_slot  <= '0;
      r_rtn_slot <= '0;
      r_rd_idx   <= '0;
      r_vreg     <= '0;
      r_data     <= '0;
      r_info     <= '0;
    end else begin
      r_act      <= 1'b1;
      r_rtn_vld  <= r_rd_req & ~w_flush;
      r_rtn_slot <= r_rd_slot;
      if (r_rtn_vld && !w_flush) r_data[r_rtn_slot] <= st.vrf_rd_data;
      if (w_flush) begin
        r_st     <= IDLE;
        r_vld    <= 1'b0;
        r_rd_req <= 1'b0;
        r_pend   <= '0;
      end else if (w_acc) begin
        r_info    <= w_info;
        r_vreg    <= w_vreg;
        r_data    <= '0;
        r_vld     <= ~|st.iq_vrf_st_src_mask;
        r_st      <= |st.iq_vrf_st_src_mask ? READ : OUT;
        r_rd_req  <= |st.iq_vrf_st_src_mask;
        r_rd_idx  <= w_vreg[w_slot];
        r_rd_slot <= w_slot;
        r_pend    <= w_nxt;
      end else if (w_hs) begin
        r_st  <= IDLE;
        r_vld <= 1'b0;
      end else if (r_st == READ) begin
        r_rd_req  <= |r_pend;
        r_rd_idx  <= r_vreg[w_slot];
        r_rd_slot <= w_slot;
        r_pend    <= w_nxt;
        if (~|r_pend) r_st <= DRAIN;
      end else if (r_st == DRAIN) begin
        r_st  <= OUT;
        r_vld <= 1'b1;
      end
    end
  assign st.vrf_rd_req             = r_rd_req;
  assign st.vrf_rd_idx             = r_rd_idx;
  assign st.vrf_vlsu_st_vld        = r_vld;
  assign st.vrf_vlsu_st_info       = r_info;
  assign st.vrf_vlsu_st_srcv0_data = r_data[0];
  assign st.vrf_vlsu_st_srcv1_data = r_data[1];
  assign st.vrf_vlsu_st_srcv2_data = r_data[2];
  assign st.vrf_vlsu_st_srcv3_data = r_data[3];
endmodule

// File: tb/tb_xpu_vpu_pc_tn_vrf_vlsu_st_pack.sv
// tb_xpu_vpu_pc_tn_vrf_vlsu_st_pack: vector table plus scoreboard bench for the store packer.
module tb_xpu_vpu_pc_tn_vrf_vlsu_st_pack;
  typedef struct {
    logic [3:0]      mask;
    logic [3:0][4:0] vr;
    logic [7:0]      uid;
    logic            opl;
    int              lat;
  } vec_t;
  typedef struct packed {
    logic [851:0]      info;
    logic [3:0][127:0] d;
  } exp_t;
  logic clk, rst_n;
  int n_chk = 0, n_err = 0;
  exp_t q[$];
  exp_t m_e;
  vec_t tbl[6];
  logic pv_stall, p_vld;
  logic [4:0] p_idx;
  logic [851:0] p_info;
  logic [3:0][127:0] p_d;
  xpu_vpu_pc_tn_vrf_vlsu_st_pack_if bus ();
`ifdef XPU_VPU_PC_TN_VLSU_ST_FLUSH_EN
  logic flush;
`endif
  xpu_vpu_pc_tn_vrf_vlsu_st_pack dut (
    .cpuclk(clk),
    .cpurst_b(rst_n),
`ifdef XPU_VPU_PC_TN_VLSU_ST_FLUSH_EN
    .rtu_vpu_flush(flush),
`endif
    .st(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [127:0] f(input logic [4:0] i);
    return {4{27'h4D2F00A, i}};
  endfunction
  function automatic logic [3:0][127:0] dut_d();
    return {bus.vrf_vlsu_st_srcv3_data, bus.vrf_vlsu_st_srcv2_data,
            bus.vrf_vlsu_st_srcv1_data, bus.vrf_vlsu_st_srcv0_data};
  endfunction
  function automatic exp_t model();
    exp_t e;
    logic [3:0][4:0] vr;
    vr = {bus.iq_vrf_st_vreg3, bus.iq_vrf_st_vreg2, bus.iq_vrf_st_vreg1, bus.iq_vrf_st_vreg0};
    e.info = '0;
    e.info[7:0]    = bus.iq_vrf_st_uid;
    e.info[29:8]   = bus.iq_vrf_st_func;
    e.info[31:30]  = bus.iq_vrf_st_vsew;
    e.info[47:32]  = bus.iq_vrf_st_vmask;
    e.info[52:48]  = bus.iq_vrf_st_vimm;
    e.info[57:53]  = bus.iq_vrf_st_ele_len;
    e.info[62:58]  = bus.iq_vrf_st_vstart_len;
    e.info[63]     = bus.iq_vrf_st_op_last;
    e.info[127:64] = bus.iq_vrf_st_src1;
    for (int i = 0; i < 4; i++) e.d[i] = bus.iq_vrf_st_src_mask[i] ? f(vr[i]) : '0;
    return e;
  endfunction
  task automatic chk(input string nm, input logic [851:0] a, input logic [851:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    end
  endtask
  // VRF read port model: data for a request shows up during the following cycle
  always @(negedge clk) begin
    bus.vrf_rd_data = p_vld ? f(p_idx) : '1;
    p_vld = rst_n & bus.vrf_rd_req;
    p_idx = bus.vrf_rd_idx;
  end
  always @(negedge clk)
    if (!rst_n) pv_stall = 1'b0;
    else begin
      if (pv_stall) begin
        chk("hold_vld", bus.vrf_vlsu_st_vld, 1'b1);
        chk("hold_info", bus.vrf_vlsu_st_info, p_info);
        chk("hold_data", dut_d(), p_d);
      end
      if (bus.vrf_vlsu_st_vld && bus.vlsu_vrf_st_rdy) begin
        if (q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL sb_empty unexpected output info=%0h", bus.vrf_vlsu_st_info);
        end else begin
          m_e = q.pop_front();
          chk("sb_info", bus.vrf_vlsu_st_info, m_e.info);
          for (int i = 0; i < 4; i++) chk($sformatf("sb_srcv%0d", i), dut_d()[i], m_e.d[i]);
        end
      end
      if (bus.iq_vrf_st_vld && bus.vrf_iq_st_rdy) q.push_back(model());
      pv_stall = bus.vrf_vlsu_st_vld & ~bus.vlsu_vrf_st_rdy;
      p_info = bus.vrf_vlsu_st_info;
      p_d = dut_d();
    end
  task automatic set_uop(input vec_t v);
    bus.iq_vrf_st_vld        = 1'b1;
    bus.iq_vrf_st_src_mask   = v.mask;
    {bus.iq_vrf_st_vreg3, bus.iq_vrf_st_vreg2, bus.iq_vrf_st_vreg1, bus.iq_vrf_st_vreg0} = v.vr;
    bus.iq_vrf_st_uid        = v.uid;
    bus.iq_vrf_st_op_last    = v.opl;
    bus.iq_vrf_st_func       = 22'($urandom);
    bus.iq_vrf_st_vsew       = 2'($urandom);
    bus.iq_vrf_st_vmask      = 16'($urandom);
    bus.iq_vrf_st_vimm       = 5'($urandom);
    bus.iq_vrf_st_ele_len    = 5'($urandom);
    bus.iq_vrf_st_vstart_len = 5'($urandom);
    bus.iq_vrf_st_src1       = {$urandom, $urandom};
  endtask
  // leaves at the negedge of the accept cycle
  task automatic send(input vec_t v);
    @(posedge clk); #1;
    set_uop(v);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.vrf_iq_st_rdy) return;
    end
    n_chk++; n_err++;
    $display("FAIL accept_timeout uid=%0h", v.uid);
  endtask
  task automatic run_vec(input vec_t v);
    logic [4:0] ei[$];
    int lat = 0;
    for (int i = 0; i < 4; i++) if (v.mask[i]) ei.push_back(v.vr[i]);
    send(v);
    @(posedge clk); #1 bus.iq_vrf_st_vld = 1'b0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(negedge clk);
      if (bus.vrf_rd_req) begin
        if (ei.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL extra_rd_req uid=%0h idx=%0d", v.uid, bus.vrf_rd_idx);
        end else chk($sformatf("rd_idx_%0h", v.uid), bus.vrf_rd_idx, ei.pop_front());
      end
      if (bus.vrf_vlsu_st_vld) lat = n;
    end
    chk($sformatf("latency_%0h", v.uid), lat, v.lat);
    chk($sformatf("rd_count_%0h", v.uid), ei.size(), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err + 1);
    $fatal(1);
  end
  initial begin
    tbl[0] = '{4'b1111, {5'd4, 5'd3, 5'd2, 5'd1},   8'h11, 1'b0, 6};
    tbl[1] = '{4'b1010, {5'd9, 5'd21, 5'd7, 5'd13}, 8'h22, 1'b0, 4};
    tbl[2] = '{4'b0000, {5'd1, 5'd2, 5'd3, 5'd4},   8'h5A, 1'b1, 1};
    tbl[3] = '{4'b0100, {5'd0, 5'd30, 5'd6, 5'd6},  8'h33, 1'b0, 3};
    tbl[4] = '{4'b1001, {5'd17, 5'd2, 5'd3, 5'd31}, 8'h44, 1'b1, 4};
    tbl[5] = '{4'b0111, {5'd25, 5'd12, 5'd0, 5'd8}, 8'h55, 1'b0, 5};
    rst_n = 1'b0;
    p_vld = 1'b0;
    p_idx = '0;
    pv_stall = 1'b0;
    bus.vlsu_vrf_st_rdy = 1'b1;
    set_uop(tbl[2]);
    bus.iq_vrf_st_vld = 1'b0;
`ifdef XPU_VPU_PC_TN_VLSU_ST_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_rdy", bus.vrf_iq_st_rdy, 1'b0);
    chk("rst_vld", bus.vrf_vlsu_st_vld, 1'b0);
    chk("rst_rd_req", bus.vrf_rd_req, 1'b0);
    chk("rst_info", bus.vrf_vlsu_st_info, '0);
    chk("rst_data", dut_d(), '0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_rdy", bus.vrf_iq_st_rdy, 1'b1);
    for (int i = 0; i < 6; i++) run_vec(tbl[i]);
    // downstream stall with a second uop waiting, then back-to-back handshake
    @(posedge clk); #1 bus.vlsu_vrf_st_rdy = 1'b0;
    run_vec(tbl[1]);
    @(posedge clk); #1 set_uop(tbl[2]);
    repeat (5) begin
      @(negedge clk);
      chk("stall_rdy", bus.vrf_iq_st_rdy, 1'b0);
      chk("stall_vld", bus.vrf_vlsu_st_vld, 1'b1);
    end
    @(posedge clk); #1 bus.vlsu_vrf_st_rdy = 1'b1;
    @(negedge clk);
    chk("b2b_rdy", bus.vrf_iq_st_rdy, 1'b1);
    @(posedge clk); #1 bus.iq_vrf_st_vld = 1'b0;
    @(negedge clk);
    chk("b2b_vld", bus.vrf_vlsu_st_vld, 1'b1);
    chk("b2b_uid", bus.vrf_vlsu_st_info[7:0], 8'h5A);
    // reset while holding a valid output
    @(posedge clk); #1 bus.vlsu_vrf_st_rdy = 1'b0;
    run_vec(tbl[3]);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", bus.vrf_vlsu_st_vld, 1'b0);
    chk("mid_rst_rdy", bus.vrf_iq_st_rdy, 1'b0);
    chk("mid_rst_info", bus.vrf_vlsu_st_info, '0);
    chk("mid_rst_data", dut_d(), '0);
    q.delete();
    @(posedge clk); #1 begin rst_n = 1'b1; bus.vlsu_vrf_st_rdy = 1'b1; end
    repeat (2) @(negedge clk);
    chk("mid_rst_idle_rdy", bus.vrf_iq_st_rdy, 1'b1);
    chk("mid_rst_idle_vld", bus.vrf_vlsu_st_vld, 1'b0);
`ifdef XPU_VPU_PC_TN_VLSU_ST_FLUSH_EN
    send(tbl[0]);
    @(posedge clk); #1 bus.iq_vrf_st_vld = 1'b0;
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    void'(q.pop_back());
    @(negedge clk);
    chk("flush_rdy", bus.vrf_iq_st_rdy, 1'b1);
    for (int i = 0; i < 6; i++) begin
      chk("flush_rd_req", bus.vrf_rd_req, 1'b0);
      chk("flush_vld", bus.vrf_vlsu_st_vld, 1'b0);
      @(negedge clk);
    end
`endif
    run_vec(tbl[4]);
    run_vec(tbl[0]);
    repeat (4) @(negedge clk);
    chk("sb_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
